// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared line-decoding modes and timing-recovery state encoding
package codec_pkg;

  localparam int MODE_NRZ  = 0;
  localparam int MODE_DIFF = 1;
  localparam int MODE_GRAY = 2;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } rec_state_t;

endpackage

// File: rtl/sym_timing_rec.sv
// rtl/sym_timing_rec.sv - transition-tracking symbol timing recovery with lock/loss detection
module sym_timing_rec
  import codec_pkg::*;
#(
  parameter int OSR    = 50,
  parameter int TOL    = 6,
  parameter int ACQ_N  = 2,
  parameter int LOSS_N = 4
) (
  input  logic                       sysclk,
  input  logic                       reset,
  input  logic                       trans,
  output logic [$clog2(OSR+1)-1:0]   phase,
  output logic                       locked,
  output logic                       sample_stb
);

  localparam int PW = $clog2(OSR + 1);
  localparam logic [PW-1:0] HALF = PW'(OSR / 2);
  localparam logic [PW-1:0] LAST = PW'(OSR - 1);
  localparam logic [PW-1:0] OSRP = PW'(OSR);
  localparam logic [PW-1:0] TOLP = PW'(TOL);
  localparam logic [7:0]    ACQ8 = 8'(ACQ_N);
  localparam logic [7:0]    LOS8 = 8'(LOSS_N);

  rec_state_t      state_q, state_d;
  logic [PW-1:0]   phase_d;
  logic [PW-1:0]   abs_err;
  logic            on_time;
  logic [7:0]      good_q, good_d, bad_q, bad_d;

  // Counts past the half symbol are early arrivals of the next symbol.
  assign abs_err    = (phase < HALF) ? phase : OSRP - phase;
  assign on_time    = (abs_err <= TOLP);
  assign sample_stb = (phase == PW'(OSR / 2 + 1));

  always_comb begin
    state_d = state_q;
    phase_d = (phase == LAST) ? '0 : phase + PW'(1);
    good_d  = good_q;
    bad_d   = bad_q;
    case (state_q)
      ST_HUNT: begin
        if (trans) begin
          phase_d = '0;
          good_d  = 8'd1;
          bad_d   = 8'd0;
          state_d = ST_ACQ;
        end
      end
      ST_ACQ: begin
        if (trans) begin
          phase_d = '0;
          if (on_time) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 >= ACQ8) begin
              state_d = ST_LOCKED;
              bad_d   = 8'd0;
            end
          end else begin
            good_d = 8'd1;
          end
        end
      end
      ST_LOCKED: begin
        // Off-time edges are distrusted: count them but keep the old alignment.
        if (trans) begin
          if (on_time) begin
            phase_d = '0;
            bad_d   = 8'd0;
          end else begin
            bad_d = bad_q + 8'd1;
            if (bad_q + 8'd1 >= LOS8) begin
              state_d = ST_HUNT;
              good_d  = 8'd0;
              bad_d   = 8'd0;
            end
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HUNT;
      phase   <= '0;
      good_q  <= 8'd0;
      bad_q   <= 8'd0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase   <= phase_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      locked  <= (state_d == ST_LOCKED);
    end
  end

endmodule

// File: rtl/sym_decoder_os.sv
// rtl/sym_decoder_os.sv - oversampling symbol decoder: input regs, mid-symbol vote, line decode
module sym_decoder_os
  import codec_pkg::*;
#(
  parameter int SYM_W  = 2,
  parameter int OSR    = 50,
  parameter int TOL    = 6,
  parameter int ACQ_N  = 2,
  parameter int LOSS_N = 4,
  parameter int MODE   = 0
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [SYM_W-1:0] in,
  output logic [SYM_W-1:0] out,
  output logic             en,
  output logic             locked,
  output logic             err
);

  localparam int PW = $clog2(OSR + 1);

  logic [SYM_W-1:0] in_q, in_d, s0, s1;
  logic [SYM_W-1:0] vote, gray_bin, dec, prev;
  logic [PW-1:0]    phase;
  logic             sample_stb, vote_err, acc;

  sym_timing_rec #(
    .OSR   (OSR),
    .TOL   (TOL),
    .ACQ_N (ACQ_N),
    .LOSS_N(LOSS_N)
  ) u_rec (
    .sysclk    (sysclk),
    .reset     (reset),
    .trans     (in_q != in_d),
    .phase     (phase),
    .locked    (locked),
    .sample_stb(sample_stb)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      in_q <= '0;
      in_d <= '0;
      s0   <= '0;
      s1   <= '0;
    end else begin
      in_q <= in;
      in_d <= in_q;
      if (phase == PW'(OSR / 2 - 1)) s0 <= in_q;
      if (phase == PW'(OSR / 2))     s1 <= in_q;
    end
  end

  // Third vote sample is in_q itself on the strobe cycle.
  assign vote     = (s0 & s1) | (s0 & in_q) | (s1 & in_q);
  assign vote_err = |((s0 ^ s1) | (s0 ^ in_q));

  always_comb begin
    acc      = 1'b0;
    gray_bin = '0;
    for (int i = SYM_W - 1; i >= 0; i--) begin
      acc         = acc ^ vote[i];
      gray_bin[i] = acc;
    end
  end

  always_comb begin
    dec = vote;
    if (MODE == MODE_DIFF)      dec = vote - prev;
    else if (MODE == MODE_GRAY) dec = gray_bin;
  end

  // Emission is gated by lock as seen at the output edge, so loss mid-symbol drops it.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      out  <= '0;
      en   <= 1'b0;
      err  <= 1'b0;
      prev <= '0;
    end else begin
      en <= 1'b0;
      if (sample_stb && locked) begin
        en   <= 1'b1;
        out  <= dec;
        err  <= vote_err;
        prev <= vote;
      end
    end
  end

endmodule

// File: tb/tb_sym_decoder_os.sv
// tb/tb_sym_decoder_os.sv - randomized bench for sym_decoder_os against a behavioural model
module tb_sym_decoder_os;

  localparam int SYM_W  = 2;
  localparam int OSR    = 50;
  localparam int TOL    = 6;
  localparam int ACQ_N  = 2;
  localparam int LOSS_N = 4;
  localparam int HALF   = OSR / 2;
  localparam int MASK   = (1 << SYM_W) - 1;

  logic             sysclk = 1'b0;
  logic             reset  = 1'b1;
  logic [SYM_W-1:0] in     = '0;
  logic [SYM_W-1:0] out_m    [3];
  logic             en_m     [3];
  logic             locked_m [3];
  logic             err_m    [3];

  for (genvar m = 0; m < 3; m++) begin : g_dut
    sym_decoder_os #(
      .SYM_W(SYM_W), .OSR(OSR), .TOL(TOL), .ACQ_N(ACQ_N), .LOSS_N(LOSS_N), .MODE(m)
    ) dut (
      .sysclk(sysclk),
      .reset (reset),
      .in    (in),
      .out   (out_m[m]),
      .en    (en_m[m]),
      .locked(locked_m[m]),
      .err   (err_m[m])
    );
  end

  always #5 sysclk = ~sysclk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // Model: line history, symbol timing position and lock bookkeeping.
  int mq, md, h1, h2, ph, mst, good, bad;
  int prev [3];
  int exp_out [3];
  bit exp_en, exp_err, exp_locked;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int decode(int m, int s, int p);
    int b;
    if (m == 1) return (s - p) & MASK;
    if (m == 2) begin
      b = s;
      for (int sh = 1; sh < SYM_W; sh++) b = b ^ (s >> sh);
      return b;
    end
    return s;
  endfunction

  function automatic void model_reset();
    mq = 0; md = 0; h1 = 0; h2 = 0; ph = 0; mst = 0; good = 0; bad = 0;
    exp_en = 0; exp_err = 0; exp_locked = 0;
    for (int m = 0; m < 3; m++) begin
      prev[m] = 0;
      exp_out[m] = 0;
    end
  endfunction

  // Advance the model across one rising edge at which 'v' is applied to the line.
  function automatic void model_edge(int v);
    bit trans, ot;
    int e, s, c, nph;
    bit er;
    trans  = (mq != md);
    exp_en = 0;
    if (ph == HALF + 1 && mst == 2) begin
      s = 0; er = 0;
      for (int b = 0; b < SYM_W; b++) begin
        c = ((h2 >> b) & 1) + ((h1 >> b) & 1) + ((mq >> b) & 1);
        if (c >= 2) s = s | (1 << b);
        if (c == 1 || c == 2) er = 1;
      end
      for (int m = 0; m < 3; m++) begin
        exp_out[m] = decode(m, s, prev[m]);
        prev[m] = s;
      end
      exp_en = 1;
      exp_err = er;
    end
    e   = (ph < HALF) ? ph : ph - OSR;
    ot  = (e <= TOL) && (e >= -TOL);
    nph = (ph + 1) % OSR;
    if (trans) begin
      if (mst == 0) begin
        nph = 0; good = 1; mst = 1;
      end else if (mst == 1) begin
        nph = 0;
        if (ot) begin
          good++;
          if (good >= ACQ_N) begin mst = 2; bad = 0; end
        end else good = 1;
      end else begin
        if (ot) begin nph = 0; bad = 0; end
        else begin
          bad++;
          if (bad >= LOSS_N) begin mst = 0; good = 0; bad = 0; end
        end
      end
    end
    ph = nph;
    h2 = h1; h1 = mq; md = mq; mq = v & MASK;
    exp_locked = (mst == 2);
  endfunction

  always @(posedge sysclk) begin
    #1;
    if (chk_on) begin
      for (int m = 0; m < 3; m++) begin
        check($sformatf("en[%0d]", m), int'(en_m[m]), int'(exp_en));
        check($sformatf("locked[%0d]", m), int'(locked_m[m]), int'(exp_locked));
        if (exp_en) begin
          check($sformatf("out[%0d]", m), int'(out_m[m]), exp_out[m]);
          check($sformatf("err[%0d]", m), int'(err_m[m]), int'(exp_err));
        end
      end
    end
  end

  task automatic tick(input int v);
    in = SYM_W'(v);
    model_edge(v);
    @(negedge sysclk);
  endtask

  task automatic hold(input int v, input int n);
    repeat (n) tick(v);
  endtask

  task automatic sym_chk(input int v, input int e_nrz, input int e_diff, input int e_gray, input int e_err);
    hold(v, 28);
    tick(v);
    check("sym_en", int'(en_m[0]), 1);
    check("sym_nrz", int'(out_m[0]), e_nrz);
    check("sym_diff", int'(out_m[1]), e_diff);
    check("sym_gray", int'(out_m[2]), e_gray);
    check("sym_err", int'(err_m[0]), e_err);
    hold(v, 21);
  endtask

  initial begin
    int sym, dur, gpos, gmask, guard;
    model_reset();
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    for (int m = 0; m < 3; m++) begin
      check("rst_out", int'(out_m[m]), 0);
      check("rst_en", int'(en_m[m]), 0);
      check("rst_locked", int'(locked_m[m]), 0);
      check("rst_err", int'(err_m[m]), 0);
    end
    chk_on = 1;

    // Acquisition: lock on the second transition, first emission 28 edges after E0.
    hold(0, 50);
    hold(3, 50);
    tick(2);
    check("lock_before", int'(locked_m[0]), 0);
    tick(2);
    check("lock_rise", int'(locked_m[0]), 1);
    hold(2, 26);
    tick(2);
    check("first_en", int'(en_m[0]), 1);
    check("first_nrz", int'(out_m[0]), 2);
    check("first_diff", int'(out_m[1]), 2);
    check("first_gray", int'(out_m[2]), 3);
    hold(2, 21);
    sym_chk(0, 0, 2, 0, 0);
    sym_chk(1, 1, 1, 1, 0);
    sym_chk(2, 2, 1, 3, 0);
    sym_chk(1, 1, 3, 1, 0);
    sym_chk(3, 3, 2, 2, 0);
    sym_chk(2, 2, 3, 3, 0);

    // One-cycle glitch on bit 0 in the middle vote sample.
    hold(1, 26);
    tick(0);
    tick(1);
    tick(1);
    check("glitch_en", int'(en_m[0]), 1);
    check("glitch_nrz", int'(out_m[0]), 1);
    check("glitch_diff", int'(out_m[1]), 3);
    check("glitch_err", int'(err_m[0]), 1);
    hold(1, 21);
    sym_chk(2, 2, 1, 3, 0);

    // Late by 6: still on time, phase realigns.
    hold(3, 56);
    sym_chk(1, 1, 2, 1, 0);
    check("lock_keep", int'(locked_m[0]), 1);

    // Late by 10 on four transitions in a row drops lock.
    hold(2, 60);
    hold(3, 60);
    hold(0, 60);
    hold(1, 60);
    tick(2);
    check("lock_hold3", int'(locked_m[0]), 1);
    tick(2);
    check("lock_fall", int'(locked_m[0]), 0);
    hold(2, 58);

    // Relock, then reset at phase 30.
    hold(0, 50);
    hold(1, 50);
    guard = 0;
    while (ph != 30 && guard < 200) begin
      tick(3);
      guard++;
    end
    check("phase30_reached", int'(guard < 200), 1);
    check("pre_rst_nrz", int'(out_m[0]), 3);
    check("pre_rst_locked", int'(locked_m[0]), 1);
    reset = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) begin
      check("arst_out", int'(out_m[m]), 0);
      check("arst_en", int'(en_m[m]), 0);
      check("arst_locked", int'(locked_m[m]), 0);
      check("arst_err", int'(err_m[m]), 0);
    end
    model_reset();
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    hold(3, 80);

    // Random symbols, jittered and occasionally wild durations, sporadic glitches.
    for (int k = 0; k < 80; k++) begin
      sym = $urandom_range(0, MASK);
      if ($urandom_range(0, 9) < 7) dur = OSR - 4 + $urandom_range(0, 8);
      else dur = $urandom_range(20, 80);
      gpos  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, dur - 1) : -1;
      gmask = $urandom_range(1, MASK);
      for (int t = 0; t < dur; t++) tick((t == gpos) ? (sym ^ gmask) : sym);
    end
    hold(0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
